shift_tx: RTL

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake and drives it onto a single serial line, one bit per clock, with framing strobes. It is the transmit end of the team's 4-bit serial-in/parallel-out shift register receiver. A receiver clocked on the same `clk` and fed from `sout` holds the transmitted word exactly WIDTH cycles after the first bit appears.

---
 rtl/shift_tx_pkg.sv | 12 +
 rtl/shift_tx.sv | 84 ++++++++
 2 files changed

// File: rtl/shift_tx_pkg.sv
// Shared types and constants for the serial transmitter and its paired receiver.
// The default width is shared so both ends of the link agree on frame size.
package shift_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/shift_tx.sv
// Parallel-in/serial-out transmitter: first bit one cycle after accept, WIDTH bits per frame;
// load_ready is high only when idle or on the last bit, so back-to-back frames run gap-free.
module shift_tx
  import shift_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             last_bit;
  logic             accept;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  end

  // Ready depends on registered state only, so no input reaches any output.
  assign last_bit   = (state == ST_SHIFT) && (cnt == LAST);
  assign load_ready = (state == ST_IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    cnt_nx     = cnt;
    sout       = 1'b0;
    sout_valid = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SHIFT;
          sreg_nx  = data_in;
          cnt_nx   = '0;
        end
      end
      ST_SHIFT: begin
        sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        sout_valid = 1'b1;
        sof        = (cnt == '0);
        eof        = last_bit;
        if (accept) begin
          sreg_nx = data_in;
          cnt_nx  = '0;
        end else begin
          sreg_nx = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          if (last_bit) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
